alsu_driver: RTL
================

# alsu_driver

Command-side initiator for the ALSU. It buffers operation requests from a valid/ready command port, drives them onto the ALSU input pins one per cycle, and tracks the ALSU's fixed pipeline latency. It captures each result from the ALSU `out` bus and returns it, tagged and in order, on a valid/ready response port. It is the only agent that drives the ALSU in the datapath, and it sits between the control sequencer and the ALSU instance.

## Interface
- `DEPTH`, default 4: depth of the command FIFO and of the response FIFO. Must be a power of 2, at least 2.
- `LAT`, default 2: ALSU latency, in edges, from pins driven to `out` valid. The ALSU registers its inputs, then registers `out`.
- `TAG_W`, default 2: width of the command/response tag.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command FIFO not full.
- `cmd_a`, `cmd_b`  in  3  operands.
- `cmd_opc`  in  3  ALSU opcode.
- `cmd_flags`  in  7  {cin, sin, dir, ropA, ropB, bpA, bpB}.
- `cmd_tag`  in  TAG_W  returned unchanged with the result.
- `alsu_a`, `alsu_b`, `alsu_opc`  out  3  ALSU operand and opcode pins (registered).
- `alsu_cin`, `alsu_sin`, `alsu_dir`, `alsu_ropA`, `alsu_ropB`, `alsu_bpA`, `alsu_bpB`  out  1 each  ALSU control pins (registered).
- `alsu_out`  in  6  ALSU result bus.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  6  result.
- `rsp_tag`  out  TAG_W  tag of the result.

## Operation
- **Command FIFO.** A write happens on an edge where `cmd_valid && cmd_ready`. `cmd_ready` is the registered not-full flag. Accepting a command when the FIFO is empty does not bypass the FIFO.
- **Issue.** On each edge, if the command FIFO is non-empty and `outstanding < DEPTH`, the driver pops the head and registers its fields onto the `alsu_*` pins. Otherwise it registers the idle pattern: all `alsu_*` pins 0. That is opcode 000 AND with A=B=0, so ALSU `out` becomes 0 and leds are unaffected.
- **Outstanding count.** `outstanding` = in-flight issues + response FIFO occupancy. This guarantees the response FIFO never overflows. Simultaneous issue and response pop leave `outstanding` unchanged.
- **In-flight tracking.** In-flight issues are tracked in a valid+tag shift register of LAT+1 stages. An issue at edge E is captured from `alsu_out` at edge E+LAT+1 into the response FIFO with its tag.
- **Response port.** `rsp_*` come from the response FIFO head. A pop happens on an edge where `rsp_valid && rsp_ready`. `rsp_data`/`rsp_tag` must hold stable while `rsp_valid && !rsp_ready`.
- **Shift/rotate (opc 100/101).** These operate on the ALSU result of the immediately preceding issue cycle. If that cycle was idle, the operand is 0. Back-to-back issue is therefore required for chained shifts; the driver does not insert idles between commands it holds.
- **No reordering or dropping.** Commands are never reordered or dropped, and results are returned in acceptance order.

## Timing
- **Reset (`rst` low).** All FIFOs and in-flight state are cleared asynchronously. While `rst` is low:
  - every `alsu_*` output is 0;
  - `rsp_valid` is 0;
  - `rsp_data` and `rsp_tag` are 0;
  - `cmd_ready` is 0.
- **After reset release.** `cmd_ready` is 1 from the first edge after release.
- **Reset mid-operation.** Queued and in-flight commands are discarded with no response. The first response after reset belongs to the first command accepted after reset.
- **Minimum latency (LAT=2).** Command accepted at edge T → issued at T+1 → captured at T+4 → `rsp_valid` high after T+4.
- **Throughput.** One command per cycle sustained while `rsp_ready` is held 1.
- **Full command FIFO.** `cmd_ready` is 0. It returns to 1 the cycle after an issue pops an entry.
- **Stalled issue.** When `outstanding = DEPTH`, issue stalls. Idle pins are driven until a response pop frees a slot; issue resumes on the edge after that pop.
- **Pointer wrap-around.** Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.

## Test plan
- **Reset.** Hold `rst` low mid-stream with 3 commands in flight → all outputs 0 immediately. After release, `cmd_ready`=1 and no stale `rsp_valid`.
- **Single add.** a=3, b=5, opc=010, cin=1, tag=2 accepted at T → `rsp_valid` after T+4, `rsp_data`=9, `rsp_tag`=2.
- **Back-to-back.** Four commands on consecutive cycles:
  - AND 6&3;
  - XOR 5^3;
  - MUL 7*7;
  - bypass B with b=6.

  → responses 2, 6, 49, 6 on consecutive cycles, tags in order.
- **Backpressure.** `rsp_ready`=0, offer 8 commands → exactly 4 issued, `cmd_ready` falls after 4 more are queued. Set `rsp_ready`=1 → all 8 results returned in order with none lost or duplicated.
- **Chained shift.** Issue bypass A with a=5, then back-to-back opc=100, dir=1, sin=1 → results 5, then 11.
- **Shift after idle.** Issue opc=101 rotate with dir=0 after one or more idle cycles → result 0.

Source files
------------

// File: rtl/alsu_driver_if.sv
// Command/response handshake bundle between the control sequencer (master) and
// alsu_driver (slave).
interface alsu_driver_if #(
  parameter int unsigned TAG_W = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_a;
  logic [2:0]       cmd_b;
  logic [2:0]       cmd_opc;
  logic [6:0]       cmd_flags;
  logic [TAG_W-1:0] cmd_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [5:0]       rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_opc, cmd_flags, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_opc, cmd_flags, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/alsu_driver.sv
// ALSU command-side initiator: buffers commands, issues one per cycle onto the ALSU pins,
// tracks the fixed pipeline latency and returns tagged results in order.
module alsu_driver #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 2,
  parameter int unsigned TAG_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  alsu_driver_if.slave bus,
  output logic [2:0]   alsu_a,
  output logic [2:0]   alsu_b,
  output logic [2:0]   alsu_opc,
  output logic         alsu_cin,
  output logic         alsu_sin,
  output logic         alsu_dir,
  output logic         alsu_ropA,
  output logic         alsu_ropB,
  output logic         alsu_bpA,
  output logic         alsu_bpB,
  input  logic [5:0]   alsu_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] MaxOut = PW'(DEPTH);

  typedef struct packed {
    logic [2:0]       a;
    logic [2:0]       b;
    logic [2:0]       opc;
    logic [6:0]       flags;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef struct packed {
    logic [5:0]       data;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t          cmd_mem [DEPTH];
  cmd_t          cmd_in;
  cmd_t          cmd_head;
  logic [PW-1:0] cmd_wr_q, cmd_wr_d;
  logic [PW-1:0] cmd_rd_q, cmd_rd_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          cmd_empty;
  logic          cmd_push;
  logic          cmd_pop;

  logic [PW-1:0] out_cnt_q, out_cnt_d;
  logic          issue;
  logic          rsp_pop;

  assign cmd_in    = {bus.cmd_a, bus.cmd_b, bus.cmd_opc, bus.cmd_flags, bus.cmd_tag};
  assign cmd_empty = (cmd_wr_q == cmd_rd_q);
  assign cmd_push  = bus.cmd_valid && cmd_ready_q;
  assign cmd_head  = cmd_mem[cmd_rd_q[AW-1:0]];

  // Issue is throttled so that every in-flight op is guaranteed a response slot.
  assign issue   = !cmd_empty && (out_cnt_q < MaxOut);
  assign cmd_pop = issue;

  always_comb begin
    cmd_wr_d    = cmd_wr_q + PW'(cmd_push);
    cmd_rd_d    = cmd_rd_q + PW'(cmd_pop);
    cmd_ready_d = !((cmd_wr_d[AW] != cmd_rd_d[AW]) &&
                    (cmd_wr_d[AW-1:0] == cmd_rd_d[AW-1:0]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_wr_q    <= '0;
      cmd_rd_q    <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      cmd_wr_q    <= cmd_wr_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_mem[cmd_wr_q[AW-1:0]] <= cmd_in;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;

  // ---------------------------------------------------------------------------
  // ALSU pin register: head fields on issue, all-zero idle pattern otherwise
  // ---------------------------------------------------------------------------
  logic [15:0] pin_q, pin_d;

  always_comb begin
    pin_d = '0;
    if (issue) begin
      pin_d = {cmd_head.a, cmd_head.b, cmd_head.opc, cmd_head.flags};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pin_q <= '0;
    end else begin
      pin_q <= pin_d;
    end
  end

  assign alsu_a    = pin_q[15:13];
  assign alsu_b    = pin_q[12:10];
  assign alsu_opc  = pin_q[9:7];
  assign alsu_cin  = pin_q[6];
  assign alsu_sin  = pin_q[5];
  assign alsu_dir  = pin_q[4];
  assign alsu_ropA = pin_q[3];
  assign alsu_ropB = pin_q[2];
  assign alsu_bpA  = pin_q[1];
  assign alsu_bpB  = pin_q[0];

  // ---------------------------------------------------------------------------
  // In-flight tracking: stage k holds the issue made k edges ago
  // ---------------------------------------------------------------------------
  logic [LAT:0]     inf_vld_q;
  logic [TAG_W-1:0] inf_tag_q [LAT+1];
  logic             capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inf_vld_q <= '0;
      for (int k = 0; k <= int'(LAT); k++) begin
        inf_tag_q[k] <= '0;
      end
    end else begin
      inf_vld_q[0] <= issue;
      inf_tag_q[0] <= issue ? cmd_head.tag : '0;
      for (int k = 1; k <= int'(LAT); k++) begin
        inf_vld_q[k] <= inf_vld_q[k-1];
        inf_tag_q[k] <= inf_tag_q[k-1];
      end
    end
  end

  // The oldest stage lines up with the ALSU output register for that issue.
  assign capture = inf_vld_q[LAT];

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  rsp_t          rsp_mem [DEPTH];
  rsp_t          rsp_head;
  rsp_t          rsp_in;
  logic [PW-1:0] rsp_wr_q;
  logic [PW-1:0] rsp_rd_q;
  logic          rsp_empty;
  logic          rsp_full;

  assign rsp_in    = '{data: alsu_out, tag: inf_tag_q[LAT]};
  assign rsp_empty = (rsp_wr_q == rsp_rd_q);
  assign rsp_full  = (rsp_wr_q[AW] != rsp_rd_q[AW]) &&
                     (rsp_wr_q[AW-1:0] == rsp_rd_q[AW-1:0]);
  assign rsp_pop   = !rsp_empty && bus.rsp_ready;
  assign rsp_head  = rsp_mem[rsp_rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_wr_q <= '0;
      rsp_rd_q <= '0;
    end else begin
      rsp_wr_q <= rsp_wr_q + PW'(capture);
      rsp_rd_q <= rsp_rd_q + PW'(rsp_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      rsp_mem[rsp_wr_q[AW-1:0]] <= rsp_in;
    end
  end

  // Gate the head so stale storage never leaks out while empty or in reset.
  assign bus.rsp_valid = !rsp_empty;
  assign bus.rsp_data  = rsp_empty ? '0 : rsp_head.data;
  assign bus.rsp_tag   = rsp_empty ? '0 : rsp_head.tag;

  // ---------------------------------------------------------------------------
  // Outstanding count: in-flight issues plus response FIFO occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    out_cnt_d = out_cnt_q + PW'(issue) - PW'(rsp_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_cnt_q <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol invariants
  // ---------------------------------------------------------------------------
  a_out_cnt_range: assert property (@(posedge clk) disable iff (!rst) out_cnt_q <= MaxOut);

  a_rsp_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    capture |-> (!rsp_full || rsp_pop));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst)
    (bus.rsp_valid && !bus.rsp_ready) |=>
      (bus.rsp_valid && $stable(bus.rsp_data) && $stable(bus.rsp_tag)));

endmodule
